// File: rtl/fetch_decode_ctrl.sv
// fetch_decode_ctrl: instruction fetch / decode / dispatch sequencer.
// Fetches a 16-bit word at pc, splits it into opcode and two 6-bit fields,
// and hands legal executor opcodes to one of four executors via a one-hot
// start line that is held until the executor reports completion.
// Optional build macro: FETCH_TIMEOUT_EN adds an 8-bit EXEC watchdog and the
// sticky err_timeout output.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | between instructions; run sampled here
// FETCH    | mem_rd asserted, mem_addr = pc
// WAIT     | instruction word on mem_data, captured into IR at cycle end
// DECODE   | donefetch pulse; branch on opcode
// DISPATCH | exec_start driven, executor being launched
// EXEC     | exec_start held until exec_done
// HALT     | terminal until rst
module fetch_decode_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic [7:0]  pc,
    output logic        mem_rd,
    output logic [7:0]  mem_addr,
    input  logic [15:0] mem_data,
    output logic        donefetch,
    output logic [5:0]  parameter1,
    output logic [5:0]  parameter2,
    output logic [3:0]  exec_start,
    input  logic        exec_done,
    output logic        halted,
    output logic        illegal
`ifdef FETCH_TIMEOUT_EN
    ,
    output logic        err_timeout
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DECODE,
        S_DISPATCH,
        S_EXEC,
        S_HALT
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] ir;
    logic        ir_load;
    logic        pc_inc;
    logic        set_illegal;
    logic [3:0]  opcode;

`ifdef FETCH_TIMEOUT_EN
    logic [7:0]  wdog;
    logic        timeout_hit;
`endif

    assign opcode     = ir[15:12];
    assign parameter1 = ir[11:6];
    assign parameter2 = ir[5:0];
    assign mem_addr   = pc;

    // Next-state decode and per-state control strobes.
    always_comb begin
        state_nxt   = state;
        ir_load     = 1'b0;
        pc_inc      = 1'b0;
        set_illegal = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        case (state)
            S_IDLE:     if (run) state_nxt = S_FETCH;
            S_FETCH:    state_nxt = S_WAIT;
            S_WAIT: begin
                ir_load   = 1'b1;
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    4'h0, 4'h1, 4'h2, 4'h3: state_nxt = S_DISPATCH;
                    4'hF:                   state_nxt = S_HALT;
                    default: begin
                        set_illegal = 1'b1;
                        pc_inc      = 1'b1;
                        state_nxt   = S_IDLE;
                    end
                endcase
            end
            S_DISPATCH: state_nxt = S_EXEC;
            S_EXEC: begin
                // exec_done wins over a watchdog expiry in the same cycle.
                if (exec_done) begin
                    pc_inc    = 1'b1;
                    state_nxt = S_IDLE;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (wdog == 8'hFF) begin
                    timeout_hit = 1'b1;
                    state_nxt   = S_HALT;
                end
`endif
            end
            S_HALT:     state_nxt = S_HALT;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Moore outputs; only opcodes 0..3 reach DISPATCH/EXEC so IR[13:12] selects the executor.
    always_comb begin
        mem_rd     = (state == S_FETCH);
        donefetch  = (state == S_DECODE);
        halted     = (state == S_HALT);
        exec_start = 4'b0000;
        if (state == S_DISPATCH || state == S_EXEC)
            exec_start = 4'b0001 << ir[13:12];
    end

    // State, IR, pc and sticky flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            ir      <= 16'h0000;
            pc      <= 8'h00;
            illegal <= 1'b0;
        end else begin
            state <= state_nxt;
            if (ir_load)     ir      <= mem_data;
            if (pc_inc)      pc      <= pc + 8'd1;
            if (set_illegal) illegal <= 1'b1;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    // Watchdog: cleared while launching, counts every EXEC cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog        <= 8'h00;
            err_timeout <= 1'b0;
        end else begin
            if (state == S_DISPATCH)  wdog <= 8'h00;
            else if (state == S_EXEC) wdog <= wdog + 8'd1;
            if (timeout_hit)          err_timeout <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Directed bench for fetch_decode_ctrl: vector table of single instructions
// plus hand sequences for halt, pc wrap, reset in EXEC and a stuck executor.
module tb_fetch_decode_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic [7:0]  pc;
    logic        mem_rd;
    logic [7:0]  mem_addr;
    logic [15:0] mem_data = 16'h0000;
    logic        donefetch;
    logic [5:0]  parameter1;
    logic [5:0]  parameter2;
    logic [3:0]  exec_start;
    logic        exec_done = 1'b0;
    logic        halted;
    logic        illegal;
`ifdef FETCH_TIMEOUT_EN
    logic        err_timeout;
`endif

    logic [15:0] mem [256];
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        logic [15:0] instr;
        int          dly;
        logic [3:0]  start;
        logic [5:0]  p1;
        logic [5:0]  p2;
        logic        ill;
        logic [7:0]  pc_after;
    } vec_t;

    vec_t vec [6];

    fetch_decode_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .pc         (pc),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .donefetch  (donefetch),
        .parameter1 (parameter1),
        .parameter2 (parameter2),
        .exec_start (exec_start),
        .exec_done  (exec_done),
        .halted     (halted),
        .illegal    (illegal)
`ifdef FETCH_TIMEOUT_EN
        ,
        .err_timeout(err_timeout)
`endif
    );

    always #5 clk = ~clk;

    // Program memory: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_rd) mem_data <= mem[mem_addr];
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_for_rd(input int limit);
        int n = 0;
        while (mem_rd !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_wait", 16'(mem_rd), 16'h0001);
    endtask

    task automatic wait_for_start(input int limit);
        int n = 0;
        while (exec_start === 4'b0000 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("start_wait", 16'(exec_start !== 4'b0000), 16'h0001);
    endtask

    initial begin
        int rd_cnt;

        vec[0] = '{16'h3045, 3, 4'b1000, 6'd1,  6'd5,  1'b0, 8'h01};
        vec[1] = '{16'h7000, 0, 4'b0000, 6'd0,  6'd0,  1'b1, 8'h02};
        vec[2] = '{16'h0ABC, 0, 4'b0001, 6'd42, 6'd60, 1'b1, 8'h03};
        vec[3] = '{16'h1FFF, 1, 4'b0010, 6'd63, 6'd63, 1'b1, 8'h04};
        vec[4] = '{16'h2041, 2, 4'b0100, 6'd1,  6'd1,  1'b1, 8'h05};
        vec[5] = '{16'hE123, 0, 4'b0000, 6'd4,  6'd35, 1'b1, 8'h06};

        for (int a = 0; a < 256; a++) mem[a] = 16'hF000;
        for (int i = 0; i < 6; i++) mem[i] = vec[i].instr;

        do_reset();
        @(negedge clk);
        chk("rst_pc", 16'(pc), 16'h0000);
        chk("rst_mem_rd", 16'(mem_rd), 16'h0000);
        chk("rst_donefetch", 16'(donefetch), 16'h0000);
        chk("rst_exec_start", 16'(exec_start), 16'h0000);
        chk("rst_halted", 16'(halted), 16'h0000);
        chk("rst_illegal", 16'(illegal), 16'h0000);
        chk("rst_params", {4'h0, parameter1, parameter2}, 16'h0000);

        // Table: run dropped after each fetch, exec_done waved outside EXEC.
        run = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_for_rd(20);
            chk("fetch_addr", 16'(mem_addr), 16'(i));
            run = 1'b0;
            exec_done = 1'b1;
            @(negedge clk);
            chk("wait_donefetch", 16'(donefetch), 16'h0000);
            @(negedge clk);
            exec_done = 1'b0;
            chk("decode_donefetch", 16'(donefetch), 16'h0001);
            chk("param1", 16'(parameter1), 16'(vec[i].p1));
            chk("param2", 16'(parameter2), 16'(vec[i].p2));
            @(negedge clk);
            if (vec[i].start != 4'b0000) begin
                chk("dispatch_start", 16'(exec_start), 16'(vec[i].start));
                for (int k = 0; k < vec[i].dly; k++) begin
                    @(negedge clk);
                    chk("exec_hold", 16'(exec_start), 16'(vec[i].start));
                end
                @(negedge clk);
                chk("exec_last", 16'(exec_start), 16'(vec[i].start));
                chk("param1_hold", 16'(parameter1), 16'(vec[i].p1));
                exec_done = 1'b1;
                @(negedge clk);
                exec_done = 1'b0;
            end
            chk("after_start", 16'(exec_start), 16'h0000);
            chk("after_pc", 16'(pc), 16'(vec[i].pc_after));
            chk("after_illegal", 16'(illegal), 16'(vec[i].ill));
            run = 1'b1;
        end

        // HALT at address 6: pc frozen, no further fetches.
        wait_for_rd(20);
        chk("halt_addr", 16'(mem_addr), 16'h0006);
        repeat (3) @(negedge clk);
        chk("halt_flag", 16'(halted), 16'h0001);
        chk("halt_pc", 16'(pc), 16'h0006);
        chk("halt_start", 16'(exec_start), 16'h0000);
        rd_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mem_rd) rd_cnt++;
        end
        chk("halt_no_rd", 16'(rd_cnt), 16'h0000);
        chk("halt_stays", 16'(halted), 16'h0001);

        // pc wrap: illegals step pc to 0xFF, then a MOV completes there.
        run = 1'b0;
        do_reset();
        for (int a = 0; a < 255; a++) mem[a] = 16'h7000;
        mem[255] = 16'h0000;
        run = 1'b1;
        wait_for_start(1500);
        chk("wrap_pc_ff", 16'(pc), 16'h00FF);
        chk("wrap_start", 16'(exec_start), 16'h0001);
        @(negedge clk);
        exec_done = 1'b1;
        @(negedge clk);
        exec_done = 1'b0;
        chk("wrap_pc_00", 16'(pc), 16'h0000);
        wait_for_rd(20);
        chk("wrap_fetch_addr", 16'(mem_addr), 16'h0000);
        run = 1'b0;

        // Reset two cycles into EXEC of the second MOV.
        do_reset();
        mem[0] = 16'h0000;
        mem[1] = 16'h0000;
        run = 1'b1;
        wait_for_start(20);
        @(negedge clk);
        exec_done = 1'b1;
        @(negedge clk);
        exec_done = 1'b0;
        wait_for_start(20);
        chk("pre_rst_pc", 16'(pc), 16'h0001);
        repeat (2) @(negedge clk);
        chk("pre_rst_start", 16'(exec_start), 16'h0001);
        rst = 1'b1;
        run = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_exec_start0", 16'(exec_start), 16'h0000);
        chk("rst_exec_pc", 16'(pc), 16'h0000);
        chk("rst_exec_illegal", 16'(illegal), 16'h0000);
        @(negedge clk);
        chk("rst_exec_idle", 16'(mem_rd), 16'h0000);

        // Idle with run low ignores exec_done; then a stuck executor.
        exec_done = 1'b1;
        repeat (3) @(negedge clk);
        exec_done = 1'b0;
        chk("idle_pc", 16'(pc), 16'h0000);
        chk("idle_no_rd", 16'(mem_rd), 16'h0000);
        run = 1'b1;
        wait_for_start(20);
        run = 1'b0;
        repeat (300) @(negedge clk);
`ifdef FETCH_TIMEOUT_EN
        chk("to_err", 16'(err_timeout), 16'h0001);
        chk("to_halted", 16'(halted), 16'h0001);
        chk("to_start", 16'(exec_start), 16'h0000);
        chk("to_pc", 16'(pc), 16'h0000);
`else
        chk("stuck_start", 16'(exec_start), 16'h0001);
        chk("stuck_halted", 16'(halted), 16'h0000);
        chk("stuck_pc", 16'(pc), 16'h0000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
